// File: rtl/chunked_serial_adder_if.sv
// ---------------------------------------------------------------------------
// chunked_serial_adder_if
//   Handshake bundle for chunked_serial_adder: an operand channel
//   (in_valid/in_ready with a, b, cin and optional sub) and a result channel
//   (out_valid/out_ready with sum, cout, ovf).
//   Optional feature macro: CSA_SUB_EN (adds the sub select signal).
//   Modports:
//     master : operand producer / result consumer (drives in_valid, a, b,
//              cin, sub, out_ready)
//     slave  : the adder (drives in_ready, out_valid, sum, cout, ovf)
// ---------------------------------------------------------------------------
interface chunked_serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CSA_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef CSA_SUB_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`endif
endinterface

// File: rtl/chunked_serial_adder.sv
// ---------------------------------------------------------------------------
// chunked_serial_adder
//   Multi-cycle adder: two WIDTH-bit operands are summed CHUNK bits per clock
//   through a single CHUNK-bit ripple stage; the inter-chunk carry is held in
//   a register. One operation takes N = WIDTH/CHUNK RUN cycles.
//   Optional feature macro: CSA_SUB_EN -- when defined, bus.sub selects a-b
//   (b inverted, carry-in forced to 1, cin ignored).
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : chunked_serial_adder_if.slave
//              in_valid/in_ready + a, b, cin, (sub)  operand handshake
//              out_valid/out_ready + sum, cout, ovf  result handshake
//   WIDTH must be a multiple of CHUNK, CHUNK >= 1.
// ---------------------------------------------------------------------------
module chunked_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  chunked_serial_adder_if.slave bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [IDX_W-1:0]  idx_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic              carry_r;
  logic [WIDTH-1:0]  sum_r;
  logic              cout_r;
  logic              ovf_r;
  logic              in_ready_r;
  logic              out_valid_r;

  logic              accept_s;
  logic              last_s;
  logic              sub_s;
  int                base_s;
  logic [WIDTH-1:0]  a_shift_s;
  logic [WIDTH-1:0]  b_shift_s;
  logic [CHUNK-1:0]  a_chunk_s;
  logic [CHUNK-1:0]  b_chunk_s;
  logic [CHUNK:0]    add_s;
  logic [CHUNK-1:0]  chunk_sum_s;
  logic              msb_cin_s;

  // Subtract select is only present in the CSA_SUB_EN build.
  always_comb begin
`ifdef CSA_SUB_EN
    sub_s = bus.sub;
`else
    sub_s = 1'b0;
`endif
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_r) begin
          accept_s = 1'b1;
          state_s  = ST_RUN;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (idx_r == LAST_IDX) begin
          last_s  = 1'b1;
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // One CHUNK-bit ripple stage on the chunk selected by idx_r.
  // The carry into the MSB is recovered from the sum bit: s = a ^ b ^ c_in.
  always_comb begin
    base_s      = int'(idx_r) * CHUNK;
    a_shift_s   = a_r >> base_s;
    b_shift_s   = b_r >> base_s;
    a_chunk_s   = a_shift_s[CHUNK-1:0];
    b_chunk_s   = b_shift_s[CHUNK-1:0];
    add_s       = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + (CHUNK+1)'(carry_r);
    chunk_sum_s = add_s[CHUNK-1:0];
    msb_cin_s   = a_chunk_s[CHUNK-1] ^ b_chunk_s[CHUNK-1] ^ chunk_sum_s[CHUNK-1];
  end

  // FSM state register; handshake flags are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == ST_IDLE);
      out_valid_r <= (state_s == ST_DONE);
    end
  end

  // Operand capture, chunk index, inter-chunk carry and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept_s) begin
      // Subtraction is a + ~b + 1, so the inversion happens once at capture.
      idx_r   <= '0;
      a_r     <= bus.a;
      b_r     <= sub_s ? ~bus.b : bus.b;
      carry_r <= sub_s ? 1'b1 : bus.cin;
    end else if (state_r == ST_RUN) begin
      sum_r   <= (sum_r & ~(CHUNK_MASK << base_s)) | (WIDTH'(chunk_sum_s) << base_s);
      carry_r <= add_s[CHUNK];
      if (last_s) begin
        idx_r  <= '0;
        cout_r <= add_s[CHUNK];
        ovf_r  <= msb_cin_s ^ add_s[CHUNK];
      end else begin
        idx_r  <= idx_r + IDX_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_chunked_serial_adder
//   Directed-vector bench for chunked_serial_adder (WIDTH=32, CHUNK=4, N=8).
//   Inputs are driven on the falling edge, outputs sampled on the falling
//   edge. Subtraction vectors run only when CSA_SUB_EN is defined.
// ---------------------------------------------------------------------------
module tb_chunked_serial_adder;

  localparam int WIDTH = 32;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sub_sel = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  chunked_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  chunked_serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef CSA_SUB_EN
  assign bus.sub = sub_sel;
`endif

  always #5 clk = ~clk;

  // Wait for in_ready, present operands for one accept edge, then scramble them.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input string nm);
    int cyc;
    @(negedge clk);
    cyc = 0;
    while (bus.in_ready !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_wait: in_ready=%b required 1", nm, bus.in_ready);
    end
    bus.a = a;
    bus.b = b;
    bus.cin = c;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.cin = 1'($urandom);
  endtask

  // Called on the falling edge just after the accept edge; checks latency and result.
  task automatic wait_result(input logic [31:0] es, input logic ec, input logic eo,
                             input string nm);
    int cyc;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc != N) begin
      miscompares++;
      $display("FAIL %s latency: got %0d cycles required %0d", nm, cyc, N);
    end
    vectors++;
    if (bus.sum !== es) begin
      miscompares++;
      $display("FAIL %s sum: got %h required %h (sub=%0b)", nm, bus.sum, es, sub_sel);
    end
    vectors++;
    if (bus.cout !== ec) begin
      miscompares++;
      $display("FAIL %s cout: got %b required %b", nm, bus.cout, ec);
    end
    vectors++;
    if (bus.ovf !== eo) begin
      miscompares++;
      $display("FAIL %s ovf: got %b required %b", nm, bus.ovf, eo);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic [31:0] es, input logic ec, input logic eo,
                        input string nm);
    start_op(a, b, c, nm);
    wait_result(es, ec, eo, nm);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s release: out_valid=%b in_ready=%b required 0/1", nm,
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    rst_n = 1'b0;
    #12;
    vectors++;
    if (bus.sum !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL reset sum: got %h required 00000000", bus.sum);
    end
    vectors++;
    if (bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset cout_ovf: got %b%b required 00", bus.cout, bus.ovf);
    end
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset out_valid: got %b required 0", bus.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset in_ready: got %b required 1", bus.in_ready);
    end
  endtask

  task automatic test_add();
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "wrap");
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "pos_ovf");
    run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0, "cin");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, "neg_ovf");
    run_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "full_ripple");
    run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0, "cin_only");
  endtask

  task automatic test_backpressure();
    bit seen;
    bus.out_ready = 1'b0;
    start_op(32'h0000_0001, 32'h0000_0002, 1'b0, "bp");
    wait_result(32'h0000_0003, 1'b0, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.in_valid = 1'b1;
        bus.a = 32'h0000_0100;
        bus.b = 32'h0000_0100;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.sum !== 32'h0000_0003 || bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: out_valid=%b sum=%h in_ready=%b required 1/00000003/0",
                 i, bus.out_valid, bus.sum, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1",
               bus.out_valid, bus.in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL bp_no_accept: out_valid seen=1 required 0");
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "rst_mid");
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.sum !== 32'h0000_0000 || bus.out_valid !== 1'b0 || bus.cout !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_clear: sum=%h out_valid=%b cout=%b required 00000000/0/0",
               bus.sum, bus.out_valid, bus.cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL rst_mid_abandon: out_valid seen=1 required 0");
    end
    run_op(32'h0000_0002, 32'h0000_0003, 1'b0, 32'h0000_0005, 1'b0, 1'b0, "after_rst");
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [31:0] first_sum;
    first_sum = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.a = 32'h0000_000A;
    bus.b = 32'h0000_0014;
    bus.cin = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // in_valid stays high with new operands; they must not disturb the first op.
    bus.a = 32'h0000_0100;
    bus.b = 32'h0000_0200;
    bus.cin = 1'b1;
    cyc = 0;
    while (bus.in_ready !== 1'b1 && cyc < 40) begin
      if (bus.out_valid === 1'b1) first_sum = bus.sum;
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (first_sum !== 32'h0000_001E) begin
      miscompares++;
      $display("FAIL b2b_first sum: got %h required 0000001E", first_sum);
    end
    vectors++;
    if (cyc != N + 1) begin
      miscompares++;
      $display("FAIL b2b_spacing: in_ready after %0d cycles required %0d", cyc, N + 1);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_result(32'h0000_0301, 1'b0, 1'b0, "b2b_second");
  endtask

`ifdef CSA_SUB_EN
  task automatic test_sub();
    sub_sel = 1'b1;
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_borrow");
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
    sub_sel = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef CSA_SUB_EN
    test_sub();
`endif
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
